fir_coef_sched: RTL and testbench

//  Sequencer for the FIR datapath block. Keeps a host-writable shadow bank of L coefficients.
//  On commit, it drives Load_x/c_in to shift the bank into the FIR, stalls the sample stream meanwhile,

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_coef_shadow.sv | 37 +++
 rtl/fir_coef_sched.sv | 156 +++++++++++++++
 tb/tb_fir_coef_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient sequencer.
// Holds the default datapath geometry, the sequencer state encoding and a
// constant-evaluable ceil(log2) helper used to size address and counter fields.
package fir_pkg;

   localparam int W1_DEF  = 9;   // sample / coefficient width
   localparam int L_DEF   = 15;  // number of taps
   localparam int LAT_DEF = 3;   // FIR latency x_in -> y_out
   localparam int WY_DEF  = 18;  // FIR output width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Smallest n with 2**n >= value.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 <<< result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fir_coef_shadow.sv
// Host-visible shadow bank of N coefficients.
// Ports:
//   clk, reset      clock and synchronous active-low reset (clears every entry)
//   we/wr_addr/wr_data   single write port; out-of-range addresses are dropped
//   rd_addr/rd_data      combinational read port; out-of-range reads return 0
module fir_coef_shadow
   import fir_pkg::*;
#(
   parameter int W  = W1_DEF,
   parameter int N  = L_DEF,
   parameter int AW = clog2(L_DEF)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem_r [N];

   // Coefficient storage: cleared on reset, written one entry per clock.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            mem_r[i] <= '0;
         end
      end else if (we && (wr_addr <= AW'(N - 1))) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = (rd_addr <= AW'(N - 1)) ? mem_r[rd_addr] : '0;

endmodule

// File: rtl/fir_coef_sched.sv
// Sequencer between the host config bus, the sample source and the FIR.
// The host fills a shadow bank; a commit shifts the bank into the FIR
// (Load_x/c_in) while the sample stream is stalled, then outputs are held
// invalid until the FIR history contains only post-load samples.
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   cfg_we, cfg_addr, cfg_data         shadow write
//   commit                             start loading the shadow bank
//   busy, cfg_err                      status / rejected-request pulse
//   s_valid, s_ready, s_data           sample input handshake
//   Load_x, x_in, c_in                 FIR control, sample and coefficient
//   y_in                               FIR output
//   m_valid, m_data                    output samples (no backpressure)
module fir_coef_sched
   import fir_pkg::*;
#(
   parameter int W1  = W1_DEF,
   parameter int L   = L_DEF,
   parameter int LAT = LAT_DEF,
   parameter int WY  = WY_DEF
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [clog2(L)-1:0]   cfg_addr,
   input  logic [W1-1:0]         cfg_data,
   input  logic                  commit,
   output logic                  busy,
   output logic                  cfg_err,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [W1-1:0]         s_data,
   output logic                  Load_x,
   output logic [W1-1:0]         x_in,
   output logic [W1-1:0]         c_in,
   input  logic [WY-1:0]         y_in,
   output logic                  m_valid,
   output logic [WY-1:0]         m_data
);

   localparam int AW = clog2(L);
   localparam int CW = clog2(LAT + L + 1);
   localparam logic [CW-1:0] LOAD_LAST  = CW'(L - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(LAT + L - 1);

   state_e          state_r, state_next_s;
   logic [CW-1:0]   cnt_r, cnt_next_s;
   logic            addr_ok_s, wr_en_s, rej_s, hs_s;
   logic [W1-1:0]   rd_data_s;
   logic [LAT-1:0]  vpipe_r;
   logic            busy_r, cfg_err_r, s_ready_r, load_x_r, m_valid_r;
   logic [W1-1:0]   x_in_r, c_in_r;

   fir_coef_shadow #(
      .W  (W1),
      .N  (L),
      .AW (AW)
   ) u_shadow (
      .clk     (clk),
      .reset   (reset),
      .we      (wr_en_s),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_addr (cnt_r[AW-1:0]),
      .rd_data (rd_data_s)
   );

   // s_ready_r mirrors (state != LOAD), so this is the accepted-sample strobe.
   assign hs_s = s_valid & s_ready_r;

   // Next-state, counter, shadow write enable and request rejection.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      wr_en_s      = 1'b0;
      rej_s        = 1'b0;
      addr_ok_s    = (cfg_addr <= AW'(L - 1));
      case (state_r)
         IDLE: begin
            // A write in the commit cycle lands before the first read in LOAD.
            wr_en_s = cfg_we & addr_ok_s;
            rej_s   = cfg_we & ~addr_ok_s;
            if (commit) begin
               state_next_s = LOAD;
               cnt_next_s   = '0;
            end else begin
               state_next_s = IDLE;
               cnt_next_s   = '0;
            end
         end
         LOAD: begin
            rej_s = cfg_we | commit;
            if (cnt_r == LOAD_LAST) begin
               state_next_s = FLUSH;
               cnt_next_s   = '0;
            end else begin
               state_next_s = LOAD;
               cnt_next_s   = cnt_r + CW'(1);
            end
         end
         FLUSH: begin
            rej_s = cfg_we | commit;
            if (cnt_r == FLUSH_LAST) begin
               state_next_s = IDLE;
               cnt_next_s   = '0;
            end else begin
               state_next_s = FLUSH;
               cnt_next_s   = cnt_r + CW'(1);
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
         end
      endcase
   end

   // State, counter, valid pipe and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         vpipe_r   <= '0;
         busy_r    <= 1'b0;
         cfg_err_r <= 1'b0;
         s_ready_r <= 1'b0;
         load_x_r  <= 1'b0;
         x_in_r    <= '0;
         c_in_r    <= '0;
         m_valid_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         cnt_r     <= cnt_next_s;
         busy_r    <= (state_next_s != IDLE);
         s_ready_r <= (state_next_s != LOAD);
         cfg_err_r <= rej_s;
         // Coefficient k is presented one clock after the LOAD cycle with cnt=k.
         load_x_r  <= (state_r == LOAD);
         c_in_r    <= (state_r == LOAD) ? rd_data_s : '0;
         // The FIR advances every clock, so idle cycles feed zeros.
         x_in_r    <= hs_s ? s_data : '0;
         vpipe_r   <= (vpipe_r << 1) | LAT'(hs_s);
         m_valid_r <= vpipe_r[LAT-1] & (state_r != FLUSH) & (state_r != LOAD);
      end
   end

   assign busy    = busy_r;
   assign cfg_err = cfg_err_r;
   assign s_ready = s_ready_r;
   assign Load_x  = load_x_r;
   assign x_in    = x_in_r;
   assign c_in    = c_in_r;
   assign m_valid = m_valid_r;
   assign m_data  = y_in;

endmodule

// File: tb/tb_fir_coef_sched.sv
// Self-checking bench for fir_coef_sched with a behavioural 15-tap FIR (latency 3).
module tb_fir_coef_sched;

   localparam int W1  = 9;
   localparam int L   = 15;
   localparam int LAT = 3;
   localparam int WY  = 18;

   typedef struct {
      int data;
      int cyc;
   } exp_t;

   logic                 clk;
   logic                 reset;
   logic                 cfg_we;
   logic [3:0]           cfg_addr;
   logic signed [W1-1:0] cfg_data;
   logic                 commit;
   logic                 busy;
   logic                 cfg_err;
   logic                 s_valid;
   logic                 s_ready;
   logic signed [W1-1:0] s_data;
   logic                 Load_x;
   logic signed [W1-1:0] x_in;
   logic signed [W1-1:0] c_in;
   logic signed [WY-1:0] y_in;
   logic                 m_valid;
   logic signed [WY-1:0] m_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   exp_t sb[$];   // expected output samples
   int   cq[$];   // expected coefficient sequence on c_in

   fir_coef_sched #(.W1(W1), .L(L), .LAT(LAT), .WY(WY)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .commit(commit), .busy(busy), .cfg_err(cfg_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .Load_x(Load_x),
      .x_in(x_in), .c_in(c_in), .y_in(y_in), .m_valid(m_valid), .m_data(m_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Behavioural FIR: coefficients shift in while Load_x, otherwise samples.
   logic signed [W1-1:0] hq[$];
   logic signed [W1-1:0] xl[L];
   logic signed [WY-1:0] yp1, yp2;
   int acc;
   initial begin
      for (int i = 0; i < L; i++) xl[i] = '0;
      yp1 = '0; yp2 = '0; y_in = '0;
   end
   always @(posedge clk) begin
      if (Load_x) begin
         hq.push_back(c_in);
         if (hq.size() > L) void'(hq.pop_front());
      end else begin
         for (int i = L - 1; i > 0; i--) xl[i] = xl[i-1];
         xl[0] = x_in;
      end
      acc = 0;
      for (int i = 0; i < hq.size(); i++) acc += int'(hq[i]) * int'(xl[i]);
      yp1  <= acc[WY-1:0];
      yp2  <= yp1;
      y_in <= yp2;
   end

   // Monitor: outputs and coefficient stream against the scoreboards.
   always @(negedge clk) begin
      exp_t e;
      int   c;
      if (m_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL m_valid_unexpected cyc=%0d data=%0d", cyc, m_data);
         end else begin
            e = sb.pop_front();
            if (int'(m_data) != e.data || cyc != e.cyc) begin
               failures++;
               $display("FAIL m_data got=%0d@%0d want=%0d@%0d", m_data, cyc, e.data, e.cyc);
            end
         end
      end
      if (Load_x) begin
         checks++;
         if (cq.size() == 0) begin
            failures++;
            $display("FAIL load_x_unexpected cyc=%0d c_in=%0d", cyc, c_in);
         end else begin
            c = cq.pop_front();
            if (int'(c_in) != c || x_in != '0) begin
               failures++;
               $display("FAIL c_in got=%0d x_in=%0d want=%0d x_in=0", c_in, x_in, c);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk(name, int'(busy), 0);
   endtask

   function automatic int hk(input int k);
      return (k >= 0 && k < L) ? k + 1 : 0;
   endfunction

   task automatic commit_pulse();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   int busy_cnt, load_cnt, nrdy_cnt;
   int pa[3] = '{1, 2, -256};
   int pb[3] = '{0, -1, 255};

   initial begin
      reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      commit = 1'b0; s_valid = 1'b0; s_data = '0;

      // 1: reset
      tick(); tick();
      chk("rst_load_x", int'(Load_x), 0);
      chk("rst_x_in", int'(x_in), 0);
      chk("rst_c_in", int'(c_in), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_s_ready", int'(s_ready), 0);
      reset = 1'b1;
      tick();
      chk("idle_s_ready", int'(s_ready), 1);
      chk("idle_busy", int'(busy), 0);

      // 2: load 1..15
      for (int k = 0; k < L; k++) begin
         cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = 9'(k + 1);
         tick();
      end
      cfg_we = 1'b0;
      for (int k = 0; k < L; k++) cq.push_back(k + 1);
      commit_pulse();
      busy_cnt = 0; load_cnt = 0; nrdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         busy_cnt += int'(busy);
         load_cnt += int'(Load_x);
         nrdy_cnt += int'(!s_ready);
      end
      tick();
      chk("load_x_cycles", load_cnt, 15);
      chk("busy_cycles", busy_cnt, 33);
      chk("s_ready_low_cycles", nrdy_cnt, 15);
      chk("coef_all_seen", cq.size(), 0);

      // 3: stream three two-sample patterns, each followed by zeros
      for (int p = 0; p < 3; p++) begin
         for (int n = 0; n < 17; n++) begin
            s_valid = 1'b1;
            s_data  = (n == 0) ? 9'(pa[p]) : (n == 1) ? 9'(pb[p]) : 9'sd0;
            chk("stream_s_ready", int'(s_ready), 1);
            sb.push_back('{pa[p] * hk(n) + pb[p] * hk(n - 1), cyc + 4});
         tick();
         end
      end
      s_valid = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("stream_drained", sb.size(), 0);

      // 4a: write to addr 15 rejected
      cfg_we = 1'b1; cfg_addr = 4'd15; cfg_data = 9'sd77;
      tick();
      cfg_we = 1'b0;
      chk("bad_addr_err", int'(cfg_err), 1);
      tick();
      chk("bad_addr_err_pulse", int'(cfg_err), 0);

      // 4b: commit + write during LOAD rejected with one pulse, no restart
      for (int k = 0; k < L; k++) cq.push_back(k + 1);
      commit_pulse();
      tick(); tick(); tick();
      commit = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 9'sd99;
      tick();
      commit = 1'b0; cfg_we = 1'b0;
      chk("busy_reject_err", int'(cfg_err), 1);
      tick();
      chk("busy_reject_pulse", int'(cfg_err), 0);
      wait_idle("reload_idle");
      chk("reload_coef_seen", cq.size(), 0);

      // 5: same-cycle write + commit; write is part of the load
      cq.push_back(-256);
      for (int k = 1; k < L; k++) cq.push_back(k + 1);
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = -9'sd256;
      commit_pulse();
      cfg_we = 1'b0;
      chk("wr_commit_no_err", int'(cfg_err), 0);
      wait_idle("wr_commit_idle");
      chk("wr_commit_coef_seen", cq.size(), 0);

      // 6: reset at LOAD cnt=7
      cq.push_back(-256);
      for (int k = 1; k < 7; k++) cq.push_back(k + 1);
      commit_pulse();
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("abort_load_x", int'(Load_x), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_c_in", int'(c_in), 0);
      chk("abort_partial_coef", cq.size(), 0);
      for (int k = 0; k < L; k++) cq.push_back(0);
      commit_pulse();
      wait_idle("abort_reload_idle");
      chk("shadow_cleared", cq.size(), 0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
